// File: rtl/y86_imem_loader_pkg.sv
// Shared types for the Y86 instruction-memory loader: FSM states, length and byte buses.
package y86_imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [LEN_W-1:0]  loader_len_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CKSUM  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    // States in which a stream byte may be accepted.
    function automatic logic is_loading(input loader_state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CKSUM);
    endfunction

endpackage

// File: rtl/y86_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface y86_imem_loader_if
    import y86_imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid_i;
    byte_t             in_data_i;
    logic              in_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    byte_t             imem_wdata_o;

    modport master (
        input  in_valid_i, in_data_i,
        output in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );

    modport slave (
        output in_valid_i, in_data_i,
        input  in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );
endinterface

// File: rtl/y86_loader_ckcnt.sv
// Payload byte counter and running XOR checksum for the loader.
module y86_loader_ckcnt
    import y86_imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_step,
    input  byte_t       i_data,
    input  loader_len_t i_len,
    output loader_len_t o_count,
    output logic        o_match_c,
    output logic        o_last_c
);

    loader_len_t r_count;
    byte_t       r_cksum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_cksum <= '0;
        end else if (i_clr) begin
            r_count <= '0;
            r_cksum <= '0;
        end else if (i_step) begin
            r_count <= r_count + LEN_W'(1);
            r_cksum <= r_cksum ^ i_data;
        end
    end

    assign o_count   = r_count;
    assign o_match_c = (r_cksum == i_data);
    // True while the byte being offered is the final payload byte.
    assign o_last_c  = ((r_count + LEN_W'(1)) == i_len);

endmodule

// File: rtl/y86_imem_loader.sv
// Streams a length-prefixed, XOR-checked program image into instruction memory
// and holds the CPU in reset until the image verifies.
module y86_imem_loader
    import y86_imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BASE_ADDR  = 0
)
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    y86_imem_loader_if.master        bus,
    output logic                     cpu_rst_o,
    output logic [ADDR_W-1:0]        boot_pc_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned MAX_LEN = IMEM_DEPTH - BASE_ADDR;

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    loader_len_t       r_len;
    loader_len_t       w_len;
    loader_len_t       w_len_next;
    loader_len_t       w_count;
    logic              w_accept;
    logic              w_arm;
    logic              w_step;
    logic              w_match_c;
    logic              w_last_c;

    logic              r_in_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    byte_t             r_wdata;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_in_ready_next;
    logic              w_we_next;
    logic [ADDR_W-1:0] w_addr_next;
    byte_t             w_wdata_next;
    logic              w_cpu_rst_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_err_next;

    assign w_accept = bus.in_valid_i && r_in_ready;
    assign w_arm    = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_step   = (r_state == ST_DATA) && w_accept;
    assign w_len    = {bus.in_data_i, r_len[7:0]};

    y86_loader_ckcnt u_ckcnt (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_clr     (w_arm),
        .i_step    (w_step),
        .i_data    (bus.in_data_i),
        .i_len     (r_len),
        .o_count   (w_count),
        .o_match_c (w_match_c),
        .o_last_c  (w_last_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) w_state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_accept) w_state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    if (32'(w_len) > MAX_LEN) w_state_next = ST_ERR;
                    else if (w_len == '0)     w_state_next = ST_CKSUM;
                    else                      w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept && w_last_c) w_state_next = ST_CKSUM;
            end
            ST_CKSUM: begin
                if (w_accept) w_state_next = w_match_c ? ST_DONE : ST_ERR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs follow the next state so they change on the deciding edge.
    always_comb begin
        w_in_ready_next = 1'b0;
        w_busy_next     = 1'b0;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;
        w_cpu_rst_next  = 1'b1;
        w_we_next       = 1'b0;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_len_next      = r_len;

        w_in_ready_next = is_loading(w_state_next);
        w_busy_next     = is_loading(w_state_next);
        w_done_next     = (w_state_next == ST_DONE);
        w_err_next      = (w_state_next == ST_ERR);
        w_cpu_rst_next  = (w_state_next != ST_DONE);

        if (w_step) begin
            w_we_next    = 1'b1;
            w_addr_next  = ADDR_W'(BASE_ADDR) + ADDR_W'(w_count);
            w_wdata_next = bus.in_data_i;
        end

        if (w_arm)                                   w_len_next = '0;
        else if (w_accept && (r_state == ST_LEN_LO)) w_len_next = LEN_W'(bus.in_data_i);
        else if (w_accept && (r_state == ST_LEN_HI)) w_len_next = w_len;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_wdata    <= '0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
        end else begin
            r_in_ready <= w_in_ready_next;
            r_we       <= w_we_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_cpu_rst  <= w_cpu_rst_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_len      <= w_len_next;
        end
    end

    assign bus.in_ready_o   = r_in_ready;
    assign bus.imem_we_o    = r_we;
    assign bus.imem_addr_o  = r_addr;
    assign bus.imem_wdata_o = r_wdata;
    assign cpu_rst_o        = r_cpu_rst;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign boot_pc_o        = ADDR_W'(BASE_ADDR);

endmodule

// File: tb/tb_y86_imem_loader.sv
// Self-checking bench for y86_imem_loader: vector table, random loads, mid-load reset.
module tb_y86_imem_loader;
    import y86_imem_loader_pkg::*;

    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned BASE_ADDR  = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] boot_pc;

    y86_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    y86_imem_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bus       (bus),
        .cpu_rst_o (cpu_rst),
        .boot_pc_o (boot_pc),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  payload_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the memory write port.
    always @(negedge clk) begin
        if (!rst && bus.imem_we_o) begin
            if (exp_addr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no write",
                         bus.imem_addr_o, bus.imem_wdata_o);
            end else begin
                chk("wr_addr", 32'(bus.imem_addr_o), 32'(exp_addr_q.pop_front()));
                chk("wr_data", 32'(bus.imem_wdata_o), 32'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic fill_payload(input int len, input bit fixed);
        payload_q = {};
        if (len > int'(IMEM_DEPTH)) return;
        for (int i = 0; i < len; i++) begin
            if (fixed) begin
                case (i)
                    0:       payload_q.push_back(8'h30);
                    1:       payload_q.push_back(8'hF2);
                    2:       payload_q.push_back(8'h0A);
                    default: payload_q.push_back(8'h00);
                endcase
            end else begin
                payload_q.push_back(8'($urandom));
            end
        end
    endtask

    // Arms a load, streams the image built from payload_q, and checks the outcome.
    // n_limit >= 0 truncates the stream after that many accepted bytes (no final checks).
    task automatic run_load(input string tag, input int len, input bit corrupt, input int gap,
                            input bit noise, input int n_limit, input bit exp_done, input bit exp_err);
        logic [7:0] stream[$];
        logic [7:0] x;
        bit         len_ok;
        int         n_send;
        int         idx;
        int         cyc;
        bit         v;
        logic       rdy;

        len_ok = (len <= int'(IMEM_DEPTH - BASE_ADDR));
        stream = {};
        stream.push_back(8'(len));
        stream.push_back(8'(len >> 8));
        x = 8'h00;
        if (len_ok) begin
            for (int i = 0; i < len; i++) begin
                stream.push_back(payload_q[i]);
                x = x ^ payload_q[i];
            end
            stream.push_back(corrupt ? (x ^ 8'h01) : x);
        end
        n_send = stream.size();
        if (n_limit >= 0 && n_limit < n_send) n_send = n_limit;
        if (len_ok) begin
            for (int i = 0; i < len; i++) begin
                if (i + 2 < n_send) begin
                    exp_addr_q.push_back(BASE_ADDR + i);
                    exp_data_q.push_back(payload_q[i]);
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_arm_busy"},  32'(busy),          32'd1);
        chk({tag, "_arm_ready"}, 32'(bus.in_ready_o), 32'd1);
        chk({tag, "_arm_done"},  32'(done),          32'd0);
        chk({tag, "_arm_err"},   32'(err),           32'd0);
        chk({tag, "_arm_cpurst"}, 32'(cpu_rst),      32'd1);

        idx = 0;
        cyc = 0;
        while (idx < n_send && cyc < 4 * (n_send + 4) + 200) begin
            @(negedge clk);
            v = ($urandom_range(99) >= gap);
            bus.in_valid_i = v;
            bus.in_data_i  = v ? stream[idx] : 8'($urandom);
            start          = noise && ($urandom_range(9) == 0);
            rdy            = bus.in_ready_o;
            @(posedge clk);
            if (v && rdy) idx++;
            cyc++;
        end
        if (idx < n_send) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: actual accepted=%0d required=%0d", tag, idx, n_send);
        end
        if (n_limit >= 0) return;

        @(negedge clk);
        bus.in_valid_i = 1'b0;
        start          = 1'b0;
        chk({tag, "_done"},    32'(done),           32'(exp_done));
        chk({tag, "_err"},     32'(err),            32'(exp_err));
        chk({tag, "_cpurst"},  32'(cpu_rst),        32'(!exp_done));
        chk({tag, "_busy"},    32'(busy),           32'd0);
        chk({tag, "_ready"},   32'(bus.in_ready_o), 32'd0);
        chk({tag, "_bootpc"},  32'(boot_pc),        32'(BASE_ADDR));
        chk({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    typedef struct {
        int len;
        bit fixed;
        bit corrupt;
        int gap;
        bit noise;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{10,      1'b1, 1'b0, 0,  1'b0, 1'b1, 1'b0};
        vecs[1] = '{10,      1'b1, 1'b1, 0,  1'b0, 1'b0, 1'b1};
        vecs[2] = '{'h401,   1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{0,       1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0};
        vecs[4] = '{0,       1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{1024,    1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{37,      1'b0, 1'b0, 50, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{5,       1'b0, 1'b1, 30, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{'hFFFF,  1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1,       1'b0, 1'b0, 60, 1'b1, 1'b1, 1'b0};

        rst            = 1'b1;
        start          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",  32'(bus.imem_addr_o),  32'(BASE_ADDR));
        chk("rst_wdata", 32'(bus.imem_wdata_o), 32'd0);
        rst = 1'b0;

        // Idle with stream traffic that must be ignored.
        repeat (5) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'($urandom);
        end
        @(negedge clk);
        chk("idle_cpurst", 32'(cpu_rst),         32'd1);
        chk("idle_ready",  32'(bus.in_ready_o),  32'd0);
        chk("idle_we",     32'(bus.imem_we_o),   32'd0);
        chk("idle_done",   32'(done),            32'd0);
        chk("idle_err",    32'(err),             32'd0);
        chk("idle_busy",   32'(busy),            32'd0);
        bus.in_valid_i = 1'b0;

        foreach (vecs[i]) begin
            fill_payload(vecs[i].len, vecs[i].fixed);
            run_load($sformatf("vec%0d", i), vecs[i].len, vecs[i].corrupt, vecs[i].gap,
                     vecs[i].noise, -1, vecs[i].exp_done, vecs[i].exp_err);
        end

        for (int r = 0; r < 6; r++) begin
            int len;
            bit corrupt;
            len     = int'($urandom_range(40));
            corrupt = 1'($urandom_range(1));
            fill_payload(len, 1'b0);
            run_load($sformatf("rnd%0d", r), len, corrupt, int'($urandom_range(60)), 1'b1, -1,
                     !corrupt, corrupt);
        end

        // Reset after the third payload byte of a 10-byte image.
        fill_payload(10, 1'b0);
        run_load("midrst", 10, 1'b0, 0, 1'b0, 5, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        bus.in_valid_i = 1'b0;
        #1;
        chk("midrst_ready",  32'(bus.in_ready_o),  32'd0);
        chk("midrst_we",     32'(bus.imem_we_o),   32'd0);
        chk("midrst_addr",   32'(bus.imem_addr_o), 32'(BASE_ADDR));
        chk("midrst_wdata",  32'(bus.imem_wdata_o), 32'd0);
        chk("midrst_cpurst", 32'(cpu_rst),         32'd1);
        chk("midrst_busy",   32'(busy),            32'd0);
        chk("midrst_done",   32'(done),            32'd0);
        chk("midrst_err",    32'(err),             32'd0);
        chk("midrst_pending", 32'(exp_addr_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        fill_payload(4, 1'b0);
        run_load("recover", 4, 1'b0, 20, 1'b0, -1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_imem_loader.md
Name: y86_imem_loader

Overview:
- Writer side of the instruction-memory interface that the SEQ fetch stage reads.
- Accepts a program image as a byte stream on a valid/ready handshake and writes it byte-by-byte into instruction memory starting at BASE_ADDR.
- Holds the CPU in reset until the image is complete and its checksum verifies, then releases the CPU with PC = BASE_ADDR.
- Sits between the host/bench byte source and the fetch-side instruction memory.

Parameters:
- IMEM_DEPTH, 1024, instruction memory size in bytes.
- ADDR_W, 10, byte-address width; must satisfy 2^ADDR_W >= IMEM_DEPTH.
- BASE_ADDR, 0, first byte address written; also the boot PC.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  one-cycle pulse that arms a new load.
- in_valid_i  in  1  stream byte valid.
- in_data_i  in  8  stream byte.
- in_ready_o  out  1  loader can accept a byte.
- imem_we_o  out  1  instruction-memory write enable.
- imem_addr_o  out  ADDR_W  instruction-memory byte address.
- imem_wdata_o  out  8  instruction-memory write data.
- cpu_rst_o  out  1  holds the CPU (PC register and register file) in reset.
- boot_pc_o  out  ADDR_W  constant BASE_ADDR.
- busy_o  out  1  a load is in progress.
- done_o  out  1  last load completed with a good checksum.
- err_o  out  1  last load failed.

Behaviour:
- Reset, asynchronous: state = IDLE, in_ready_o = 0, imem_we_o = 0, imem_addr_o = BASE_ADDR, imem_wdata_o = 0, cpu_rst_o = 1, busy_o = 0, done_o = 0, err_o = 0, length = 0, count = 0, checksum = 0.
- A byte is accepted when in_valid_i && in_ready_o are both high at a rising edge.
- in_ready_o = 1 only in LEN_LO, LEN_HI, DATA and CKSUM.
- Stream format: LEN[7:0], LEN[15:8] (little endian, as Y86), then LEN payload bytes, then one byte equal to the XOR of all payload bytes.
- State transitions:
  - IDLE: start_i -> LEN_LO. Stream bytes are ignored (in_ready_o = 0).
  - LEN_LO: on accept, latch the low byte -> LEN_HI.
  - LEN_HI: on accept, form LEN.
    - LEN > IMEM_DEPTH - BASE_ADDR -> ERR.
    - LEN == 0 -> CKSUM.
    - Otherwise -> DATA.
  - DATA: on each accept, write the byte at BASE_ADDR + count, increment count, XOR the byte into checksum. The accept of payload byte LEN-1 -> CKSUM.
  - CKSUM: on accept, compare against checksum. Match -> DONE, mismatch -> ERR.
  - DONE: cpu_rst_o = 0, done_o = 1. start_i -> LEN_LO.
  - ERR: cpu_rst_o = 1, err_o = 1. start_i -> LEN_LO.
- Write port timing: registered. imem_we_o is high for exactly the one cycle after each accepted payload byte, with imem_addr_o and imem_wdata_o valid in that same cycle. imem_we_o is never high outside payload writes.
- Arming: entry to LEN_LO clears count, checksum, done_o and err_o, and sets cpu_rst_o = 1 and busy_o = 1 (registered, effective the cycle after start_i).
- busy_o = 1 in LEN_LO, LEN_HI, DATA and CKSUM.
- start_i during LEN_LO/LEN_HI/DATA/CKSUM is ignored; the load continues.
- in_valid_i low inserts stalls; no timeout, state is held.
- cpu_rst_o falls on the same edge at which done_o rises, so fetch starts at boot_pc_o on the next cycle.
- Address wrap: cannot occur because LEN is bounds-checked. LEN == IMEM_DEPTH - BASE_ADDR is legal and fills to the last byte.
- Reset asserted mid-load aborts the load: outputs return to reset values, memory contents already written are left untouched, and the CPU stays in reset.

Decomposition:
- Shared package (define.v): loader state encodings (3-bit), LOADER_LEN_BUS [15:0], and the byte bus width.
- One natural sub-module: y86_loader_ckcnt, holding the payload counter and the running XOR checksum, with clear/step/compare. The FSM and write-port registers stay in the top level.

Test Plan:
- Reset, then 5 idle cycles -> cpu_rst_o = 1, in_ready_o = 0, imem_we_o = 0, done_o = 0, err_o = 0.
- start_i, then stream 0A 00 30 F2 0A 00 00 00 00 00 00 00 C8 -> ten writes at addresses 0..9 with data 30 F2 0A 00 .. 00; done_o = 1 and cpu_rst_o = 0 on the CKSUM accept edge; boot_pc_o = 0.
- Same image with checksum C9 -> ten writes occur, err_o = 1, done_o = 0, cpu_rst_o stays 1.
- LEN = 0x0401 with IMEM_DEPTH 1024 -> ERR after the second byte, no writes.
- LEN = 0, checksum 00 -> DONE, no writes.
- Random in_valid_i gaps plus start_i pulses mid-DATA -> byte order and addresses are unchanged and start_i is ignored. A separate run asserts rst_i after payload byte 3 -> all outputs return to reset values asynchronously.
